// File: rtl/cpu16_pkg.sv
// cpu16_pkg: shared widths, instruction field positions and opcodes for the cpu16 datapath
package cpu16_pkg;
  localparam int DW = 16;
  localparam int NREG = 16;
  localparam int NMEM = 16;
  localparam int FW = 4;
  localparam int IMM_W = 8;
  localparam int OP_LSB = 12;
  localparam int RD_LSB = 8;
  localparam int RS_LSB = 4;
  localparam int RT_LSB = 0;
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_STORE = 4'h3;
  localparam logic [3:0] OP_LOAD = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_OR = 4'h6;
  localparam logic [3:0] OP_XOR = 4'h7;
  localparam logic [3:0] OP_SLL = 4'h8;
  localparam logic [3:0] OP_SRL = 4'h9;
  localparam logic [3:0] OP_SRA = 4'hA;
  localparam logic [3:0] OP_SLT = 4'hB;
  localparam logic [3:0] OP_LI = 4'hC;
  localparam logic [3:0] OP_LUI = 4'hD;
  localparam logic [3:0] OP_ADDI = 4'hE;
endpackage

// File: rtl/cpu16_regfile.sv
// cpu16_regfile: 16x16 register file, three combinational reads, one sync write, sync clear
module cpu16_regfile
  import cpu16_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [FW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic [FW-1:0] ra_s,
  input  logic [FW-1:0] ra_t,
  input  logic [FW-1:0] ra_d,
  output logic [DW-1:0] rd_s,
  output logic [DW-1:0] rd_t,
  output logic [DW-1:0] rd_d
);
  logic [DW-1:0] r [NREG];
  assign rd_s = r[ra_s];
  assign rd_t = r[ra_t];
  assign rd_d = r[ra_d];
  always_ff @(posedge clk) begin
    if (rst) for (int i = 0; i < NREG; i++) r[i] <= '0;
    else if (we) r[wa] <= wd;
  end
endmodule

// File: rtl/cpu16_top.sv
// cpu16_top: single-issue 16-bit execute datapath; data memory for STORE/LOAD only with CPU16_DMEM_EN
module cpu16_top
  import cpu16_pkg::*;
(
  input  logic          CLK,
  input  logic          RSTn,
  input  logic [DW-1:0] IR,
  output logic [DW-1:0] DATA1_OUT,
  output logic [DW-1:0] DATA2_OUT,
  output logic [DW-1:0] DATA3_OUT,
  output logic [FW-1:0] ALU_SEL
);
  logic [DW-1:0] ir_q, rs_val, rt_val, rd_val, a, b, res;
  logic signed [DW-1:0] sra;
  logic [FW-1:0] op, rd, rs, rt;
  logic [IMM_W-1:0] imm;
  logic we, fire;
  assign op = IR[OP_LSB +: FW];
  assign rd = IR[RD_LSB +: FW];
  assign rs = IR[RS_LSB +: FW];
  assign rt = IR[RT_LSB +: FW];
  assign imm = IR[IMM_W-1:0];
  assign fire = IR != ir_q;
  assign sra = $signed(rs_val) >>> rt;
  cpu16_regfile u_rf (
    .clk(CLK), .rst(RSTn), .we(fire && we), .wa(rd), .wd(res),
    .ra_s(rs), .ra_t(rt), .ra_d(rd), .rd_s(rs_val), .rd_t(rt_val), .rd_d(rd_val)
  );
`ifdef CPU16_DMEM_EN
  logic [DW-1:0] mem [NMEM];
  logic [DW-1:0] mem_rd;
  assign mem_rd = mem[rt];
  always_ff @(posedge CLK) begin
    if (RSTn) for (int i = 0; i < NMEM; i++) mem[i] <= '0;
    else if (fire && op == OP_STORE) mem[rt] <= rd_val;
  end
`endif
  always_comb begin
    a = '0;
    b = '0;
    res = '0;
    we = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT: begin
        a = rs_val;
        b = rt_val;
        we = 1'b1;
        res = op == OP_ADD ? rs_val + rt_val :
              op == OP_SUB ? rs_val - rt_val :
              op == OP_AND ? rs_val & rt_val :
              op == OP_OR  ? rs_val | rt_val :
              op == OP_XOR ? rs_val ^ rt_val :
              {{(DW-1){1'b0}}, $signed(rs_val) < $signed(rt_val)};
      end
      OP_SLL, OP_SRL, OP_SRA: begin
        a = rs_val;
        b = {{(DW-FW){1'b0}}, rt};
        we = 1'b1;
        res = op == OP_SLL ? rs_val << rt : op == OP_SRL ? rs_val >> rt : sra;
      end
      OP_LI: begin
        b = {{(DW-IMM_W){1'b0}}, imm};
        res = b;
        we = 1'b1;
      end
      OP_LUI: begin
        a = rd_val;
        b = {imm, {(DW-IMM_W){1'b0}}};
        res = {imm, rd_val[IMM_W-1:0]};
        we = 1'b1;
      end
      OP_ADDI: begin
        a = rd_val;
        b = {{(DW-IMM_W){imm[IMM_W-1]}}, imm};
        res = rd_val + {{(DW-IMM_W){imm[IMM_W-1]}}, imm};
        we = 1'b1;
      end
`ifdef CPU16_DMEM_EN
      OP_STORE: begin
        a = {{(DW-FW){1'b0}}, rt};
        b = rd_val;
        res = rd_val;
      end
      OP_LOAD: begin
        a = {{(DW-FW){1'b0}}, rt};
        b = mem_rd;
        res = mem_rd;
        we = 1'b1;
      end
`endif
      default: ;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RSTn) begin
      ir_q <= '0;
      DATA1_OUT <= '0;
      DATA2_OUT <= '0;
      DATA3_OUT <= '0;
      ALU_SEL <= '0;
    end else if (fire) begin
      ir_q <= IR;
      DATA1_OUT <= a;
      DATA2_OUT <= b;
      DATA3_OUT <= res;
      ALU_SEL <= op;
    end
  end
endmodule

// File: tb/tb_cpu16_top.sv
// tb_cpu16_top: directed plan plus random instructions against an arithmetic reference model
module tb_cpu16_top;
  logic CLK = 1'b0;
  logic RSTn = 1'b1;
  logic [15:0] IR = 16'h0000;
  logic [15:0] DATA1_OUT, DATA2_OUT, DATA3_OUT;
  logic [3:0] ALU_SEL;
  int n_checks = 0;
  int n_errors = 0;
  int R [16];
  int M [16];
  int irq, ea, eb, er, eop;

  cpu16_top dut (
    .CLK(CLK), .RSTn(RSTn), .IR(IR),
    .DATA1_OUT(DATA1_OUT), .DATA2_OUT(DATA2_OUT), .DATA3_OUT(DATA3_OUT), .ALU_SEL(ALU_SEL)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int sx(input int v);
    return v >= 32768 ? v - 65536 : v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      R[i] = 0;
      M[i] = 0;
    end
    irq = 0; ea = 0; eb = 0; er = 0; eop = 0;
  endtask

  task automatic model_exec(input logic [15:0] ir);
    int op, rd, rs, rt, a, b, r, w;
    if (int'(ir) == irq) return;
    irq = int'(ir);
    op = int'(ir[15:12]); rd = int'(ir[11:8]); rs = int'(ir[7:4]); rt = int'(ir[3:0]);
    a = 0; b = 0; r = 0; w = 0;
    case (op)
      1, 2, 5, 6, 7, 11: begin
        a = R[rs]; b = R[rt]; w = 1;
        case (op)
          1: r = a + b;
          2: r = a - b;
          5: r = a & b;
          6: r = a | b;
          7: r = a ^ b;
          default: r = sx(a) < sx(b) ? 1 : 0;
        endcase
      end
      8, 9, 10: begin
        a = R[rs]; b = rt; w = 1;
        r = op == 8 ? a * (1 << b) : op == 9 ? a / (1 << b) : sx(a) >>> b;
      end
      12: begin b = int'(ir[7:0]); r = b; w = 1; end
      13: begin a = R[rd]; b = int'(ir[7:0]) * 256; r = b + (a % 256); w = 1; end
      14: begin a = R[rd]; b = ir[7] ? int'(ir[7:0]) + 65280 : int'(ir[7:0]); r = a + b; w = 1; end
`ifdef CPU16_DMEM_EN
      3: begin a = rt; b = R[rd]; r = b; M[rt] = b; end
      4: begin a = rt; b = M[rt]; r = b; w = 1; end
`endif
      default: ;
    endcase
    r = r & 65535;
    if (w != 0) R[rd] = r;
    ea = a; eb = b; er = r; eop = op;
  endtask

  task automatic check_out(input string tag);
    check({tag, ".d1"}, DATA1_OUT, 16'(ea));
    check({tag, ".d2"}, DATA2_OUT, 16'(eb));
    check({tag, ".d3"}, DATA3_OUT, 16'(er));
    check({tag, ".sel"}, {12'h000, ALU_SEL}, 16'(eop));
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 16; i++) check($sformatf("%s.r%0d", tag, i), dut.u_rf.r[i], 16'(R[i]));
  endtask

  task automatic step(input logic [15:0] ir, input logic rst, input string tag);
    @(negedge CLK);
    IR = ir;
    RSTn = rst;
    @(posedge CLK);
    if (rst) model_reset();
    else model_exec(ir);
    #1;
    check_out(tag);
  endtask

  logic [15:0] li_seq [5] = '{16'hC011, 16'hC112, 16'hC213, 16'hC313, 16'hC415};
  logic [15:0] li_seq2 [5] = '{16'hC011, 16'hC112, 16'hC213, 16'hC314, 16'hC415};
  logic [15:0] chain [8] = '{16'h7030, 16'h8801, 16'h6C32, 16'hA132, 16'hBFF2, 16'hE0FF, 16'h0000, 16'hE0FF};

  initial begin
    logic [15:0] last;
    model_reset();
    step(16'h1234, 1'b1, "rst0");
    step(16'h1234, 1'b1, "rst1");
    step(16'h0000, 1'b0, "rel");
    check("rst.d1", DATA1_OUT, 16'h0000);
    check("rst.sel", {12'h000, ALU_SEL}, 16'h0000);
    check_regs("rst");
    foreach (li_seq[i]) step(li_seq[i], 1'b0, "li");
    check("li.d2", DATA2_OUT, 16'h0015);
    check("li.d3", DATA3_OUT, 16'h0015);
    check("li.sel", {12'h000, ALU_SEL}, 16'h000C);
    check("li.r3", dut.u_rf.r[3], 16'h0013);
    check_regs("li");
    step(16'h3000, 1'b0, "st0");
    step(16'h3101, 1'b0, "st1");
    step(16'h4501, 1'b0, "ld");
    for (int i = 0; i < 50; i++) step(16'h4501, 1'b0, "hold");
    check_regs("hold");
    foreach (li_seq2[i]) step(li_seq2[i], 1'b0, "li2");
    step(chain[0], 1'b0, "xor");
    check("xor.r0", dut.u_rf.r[0], 16'h0005);
    step(chain[1], 1'b0, "sll");
    check("sll.r8", dut.u_rf.r[8], 16'h000A);
    step(chain[2], 1'b0, "or");
    check("or.r12", dut.u_rf.r[12], 16'h0017);
    check("or.d1", DATA1_OUT, 16'h0014);
    check("or.d2", DATA2_OUT, 16'h0013);
    step(chain[3], 1'b0, "sra");
    check("sra.r1", dut.u_rf.r[1], 16'h0005);
    step(chain[4], 1'b0, "slt");
    check("slt.r15", dut.u_rf.r[15], 16'h0001);
    for (int i = 5; i < 8; i++) step(chain[i], 1'b0, "addi");
    check("addi.r0", dut.u_rf.r[0], 16'h0003);
    check_regs("chain");
    step(16'hC0AB, 1'b0, "pre");
    step(16'h1234, 1'b1, "rstnew");
    check_regs("rstnew");
    step(16'hC0AB, 1'b1, "rsthold");
    step(16'hC0AB, 1'b0, "again");
    check("again.r0", dut.u_rf.r[0], 16'h00AB);
    last = 16'hC0AB;
    for (int n = 0; n < 400; n++) begin
      logic [15:0] ir;
      int k;
      k = int'($urandom_range(0, 99));
      ir = k < 20 ? last : 16'($urandom);
      if (k >= 20 && k < 30) ir[15:12] = 4'($urandom_range(3, 4));
      step(ir, k >= 97, $sformatf("rnd%0d", n));
      check_regs($sformatf("rnd%0d", n));
      last = ir;
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
